spic_seq: RTL and testbench

Synthesizable instruction sequencer feeding the SPI controller master. It buffers host-written instruction words in a FIFO and hands them to the master on each `driver_read` fetch pulse, under a batch enable. It captures `spi_slv_read_data` for completed read instructions into a response FIFO. It sits between the host/CPU side and the SPI master, generalising the simulation-only driver with parametrised depths, backpressure, batching and error reporting.

---
 rtl/spic_pkg.sv | 36 +++
 rtl/spic_seq_fifo.sv | 57 +++++
 rtl/spic_seq.sv | 174 +++++++++++++++++
 tb/tb_spic_seq.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spic_pkg
//  Description : Shared constants, instruction field offsets and sequencer
//                state encoding for the SPI controller instruction sequencer.
//                RSP_W depends on the SPIC_SEQ_TAG_EN macro.
//  Revision    : 1.0 - initial release
// ============================================================================
package spic_pkg;

  localparam int DWIDTH       = 8;
  localparam int AWIDTH       = 8;
  localparam int S_ADDR_WIDTH = 2;
  localparam int INSTR_SIZE   = S_ADDR_WIDTH + 2 + 2 + AWIDTH + DWIDTH;

  // Instruction word layout, MSB first: {SS, T_TYPE[1:0], SIZE[1:0], ADDR, WDATA}
  localparam int SS_LSB    = INSTR_SIZE - S_ADDR_WIDTH;
  localparam int TTYPE_LSB = SS_LSB - 2;
  localparam int SIZE_LSB  = TTYPE_LSB - 2;
  localparam int ADDR_LSB  = SIZE_LSB - AWIDTH;

`ifdef SPIC_SEQ_TAG_EN
  // Responses carry the slave select and address of the originating read
  localparam int RSP_W = S_ADDR_WIDTH + AWIDTH + DWIDTH;
`else
  localparam int RSP_W = DWIDTH;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } spic_seq_state_e;

endpackage
`default_nettype wire

// File: rtl/spic_seq_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : spic_seq_fifo
//  Description : Generic synchronous FIFO with a flop-based head and
//                full/empty flags. A push while full is accepted only when a
//                pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module spic_seq_fifo
  import spic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care until the pointers cover them
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/spic_seq.sv
`default_nettype none
// ============================================================================
//  Module      : spic_seq
//  Description : Instruction sequencer for the SPI controller master. Buffers
//                host instructions, hands them out on driver_read fetch
//                pulses during a batch, and collects read data into a
//                response FIFO with sticky overflow reporting.
//                Macro SPIC_SEQ_TAG_EN: responses tagged with {SS, ADDR}.
//  Revision    : 1.0 - initial release
// ============================================================================
module spic_seq
  import spic_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int RSP_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [INSTR_SIZE-1:0] cmd_data,
  input  logic                  start,
  input  logic [1:0]            cfg,
  input  logic                  driver_read,
  input  logic [DWIDTH-1:0]     spi_slv_read_data,
  output logic                  master_en,
  output logic [INSTR_SIZE-1:0] driver_data,
  output logic [1:0]            driver_cfg,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [RSP_W-1:0]      rsp_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err_ovf
);

  spic_seq_state_e state;
  spic_seq_state_e state_nxt;

  logic [INSTR_SIZE-1:0] ififo_head;
  logic                  ififo_full;
  logic                  ififo_empty;
  logic [RSP_W-1:0]      rfifo_head;
  logic                  rfifo_full;
  logic                  rfifo_empty;
  logic [RSP_W-1:0]      rsp_wdata;

  logic cmd_push;
  logic fetch;
  logic ififo_pop;
  logic start_run;
  logic rsp_pop;
  logic rsp_push;
  logic rsp_drop;

  // Pending register: the instruction the master is currently executing
  logic pend_valid;
  logic pend_read;
`ifdef SPIC_SEQ_TAG_EN
  logic [S_ADDR_WIDTH-1:0] pend_ss;
  logic [AWIDTH-1:0]       pend_addr;
`endif

  assign cmd_ready = !ififo_full;
  assign cmd_push  = cmd_valid && cmd_ready;
  assign fetch     = (state == RUN) && driver_read;
  // No bypass: a closing pulse only looks at what is already stored
  assign ififo_pop = fetch && !ififo_empty;
  assign start_run = (state == IDLE) && start && !ififo_empty;
  assign rsp_valid = !rfifo_empty;
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign rsp_push  = fetch && pend_valid && pend_read;
  assign rsp_drop  = rsp_push && rfifo_full && !rsp_pop;
  assign rsp_data  = rsp_valid ? rfifo_head : '0;
  assign driver_data = ((state == RUN) && !ififo_empty) ? ififo_head : '0;

`ifdef SPIC_SEQ_TAG_EN
  assign rsp_wdata = {pend_ss, pend_addr, spi_slv_read_data};
`else
  assign rsp_wdata = spi_slv_read_data;
`endif

  spic_seq_fifo #(
    .WIDTH (INSTR_SIZE),
    .DEPTH (DEPTH)
  ) u_ififo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_push),
    .wdata (cmd_data),
    .pop   (ififo_pop),
    .head  (ififo_head),
    .full  (ififo_full),
    .empty (ififo_empty)
  );

  spic_seq_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (RSP_DEPTH)
  ) u_rfifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rsp_push),
    .wdata (rsp_wdata),
    .pop   (rsp_pop),
    .head  (rfifo_head),
    .full  (rfifo_full),
    .empty (rfifo_empty)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_nxt = state;
    master_en = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ififo_empty ? DONE : RUN;
      end
      RUN: begin
        master_en = 1'b1;
        busy      = 1'b1;
        if (driver_read && ififo_empty) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pending instruction capture on every fetch; an empty fetch closes it out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_read  <= 1'b0;
`ifdef SPIC_SEQ_TAG_EN
      pend_ss    <= '0;
      pend_addr  <= '0;
`endif
    end else if (fetch) begin
      pend_valid <= !ififo_empty;
      pend_read  <= !ififo_head[TTYPE_LSB];
`ifdef SPIC_SEQ_TAG_EN
      pend_ss    <= ififo_head[SS_LSB +: S_ADDR_WIDTH];
      pend_addr  <= ififo_head[ADDR_LSB +: AWIDTH];
`endif
    end
  end

  // Config latch and sticky overflow flag, both renewed by an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      driver_cfg <= 2'b00;
      err_ovf    <= 1'b0;
    end else if (start_run) begin
      driver_cfg <= cfg;
      err_ovf    <= 1'b0;
    end else if (rsp_drop) begin
      err_ovf    <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spic_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spic_seq
//  Description : Self-checking bench for spic_seq (DEPTH=4, RSP_DEPTH=2).
//                Expected responses follow SPIC_SEQ_TAG_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spic_seq;
  import spic_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  cmd_valid = 1'b0;
  logic [INSTR_SIZE-1:0] cmd_data = '0;
  logic                  start = 1'b0;
  logic [1:0]            cfg = 2'b00;
  logic                  driver_read = 1'b0;
  logic [DWIDTH-1:0]     rd_data = '0;
  logic                  rsp_ready = 1'b0;
  logic                  cmd_ready;
  logic                  master_en;
  logic [INSTR_SIZE-1:0] driver_data;
  logic [1:0]            driver_cfg;
  logic                  rsp_valid;
  logic [RSP_W-1:0]      rsp_data;
  logic                  busy;
  logic                  done;
  logic                  err_ovf;

  int n_cmp = 0;
  int n_fail = 0;
  int done_cnt = 0;

  spic_seq #(.DEPTH(4), .RSP_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .start(start), .cfg(cfg), .driver_read(driver_read),
    .spi_slv_read_data(rd_data), .master_en(master_en), .driver_data(driver_data),
    .driver_cfg(driver_cfg), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .busy(busy), .done(done), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  // Count done pulses as seen at the sampling edge
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  typedef struct {
    logic [INSTR_SIZE-1:0] instr;
    logic                  is_read;
    logic [DWIDTH-1:0]     rdata;
    logic [RSP_W-1:0]      rsp;
  } vec_t;

  vec_t tbl[3];

  function automatic logic [INSTR_SIZE-1:0] mk(input logic wr, input logic [1:0] ss,
                                               input logic [7:0] addr, input logic [7:0] wd);
    return {ss, 1'b0, wr, 2'b00, addr, wd};
  endfunction

  function automatic logic [RSP_W-1:0] exp_rsp(input logic [1:0] ss, input logic [7:0] addr,
                                               input logic [7:0] rd);
`ifdef SPIC_SEQ_TAG_EN
    return {ss, addr, rd};
`else
    return rd;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic push(input logic [INSTR_SIZE-1:0] instr);
    cmd_valid = 1'b1;
    cmd_data  = instr;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [1:0] c);
    start = 1'b1;
    cfg   = c;
    @(negedge clk);
    start = 1'b0;
    cfg   = 2'b00;
  endtask

  task automatic pulse_read(input logic [DWIDTH-1:0] d);
    driver_read = 1'b1;
    rd_data     = d;
    @(negedge clk);
    driver_read = 1'b0;
    rd_data     = '0;
  endtask

  task automatic pop_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic gap();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int base;
    logic [INSTR_SIZE-1:0] w2, w3, t6;

    tbl[0] = '{mk(1'b1, 2'b01, 8'h04, 8'hA5), 1'b0, 8'h00, '0};
    tbl[1] = '{mk(1'b0, 2'b01, 8'h04, 8'h00), 1'b1, 8'hA5, exp_rsp(2'b01, 8'h04, 8'hA5)};
    tbl[2] = '{mk(1'b0, 2'b01, 8'h08, 8'h00), 1'b1, 8'h3C, exp_rsp(2'b01, 8'h08, 8'h3C)};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_master_en", master_en, 0);
    chk("rst_driver_data", driver_data, 0);
    chk("rst_driver_cfg", driver_cfg, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_ovf", err_ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: mixed batch, master pulses every 40 cycles
    base = done_cnt;
    for (int i = 0; i < 3; i++) begin
      chk("t1_cmd_ready", cmd_ready, 1);
      push(tbl[i].instr);
    end
    chk("t1_idle_drv", driver_data, 0);
    pulse_start(2'b10);
    chk("t1_master_en", master_en, 1);
    chk("t1_busy", busy, 1);
    chk("t1_cfg", driver_cfg, 2'b10);
    for (int k = 0; k < 4; k++) begin
      repeat (39) @(negedge clk);
      if (k < 3) chk("t1_drv_head", driver_data, tbl[k].instr);
      else       chk("t1_drv_empty", driver_data, 0);
      chk("t1_en_before", master_en, 1);
      pulse_read((k > 0) ? tbl[k-1].rdata : 8'hEE);
      if (k < 3) begin
        chk("t1_en_after", master_en, 1);
        chk("t1_done_low", done, 0);
      end else begin
        chk("t1_close_en", master_en, 0);
        chk("t1_close_done", done, 1);
        chk("t1_close_busy", busy, 1);
      end
      if (k > 0 && tbl[k-1].is_read) begin
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_data", rsp_data, tbl[k-1].rsp);
        pop_rsp();
      end
      chk("t1_rsp_drained", rsp_valid, 0);
    end
    chk("t1_busy_end", busy, 0);
    chk("t1_err", err_ovf, 0);
    @(negedge clk);
    chk("t1_done_count", done_cnt - base, 1);

    // Test 2: start with an empty instruction FIFO
    base = done_cnt;
    pulse_start(2'b01);
    chk("t2_done", done, 1);
    chk("t2_busy", busy, 1);
    chk("t2_en", master_en, 0);
    @(negedge clk);
    chk("t2_done_end", done, 0);
    chk("t2_busy_end", busy, 0);
    chk("t2_en_end", master_en, 0);
    @(negedge clk);
    chk("t2_done_count", done_cnt - base, 1);

    // Test 3: instruction FIFO full, then response overflow
    for (int i = 0; i < 4; i++) push(mk(1'b0, 2'b11, 8'h10 + 8'(i), 8'h00));
    chk("t3_cmd_full", cmd_ready, 0);
    pulse_start(2'b01);
    pulse_read(8'hEE);
    chk("t3_cmd_free", cmd_ready, 1);
    gap();
    pulse_read(8'h11);
    chk("t3_rsp1_valid", rsp_valid, 1);
    gap();
    pulse_read(8'h22);
    gap();
    // Push and pop together on a full response FIFO: nothing lost
    rsp_ready = 1'b1; driver_read = 1'b1; rd_data = 8'h33;
    @(negedge clk);
    rsp_ready = 1'b0; driver_read = 1'b0; rd_data = '0;
    chk("t3_pushpop_noovf", err_ovf, 0);
    chk("t3_pushpop_head", rsp_data, exp_rsp(2'b11, 8'h11, 8'h22));
    gap();
    pulse_read(8'h44);
    chk("t3_ovf_set", err_ovf, 1);
    chk("t3_close_done", done, 1);
    chk("t3_head_a", rsp_data, exp_rsp(2'b11, 8'h11, 8'h22));
    pop_rsp();
    chk("t3_head_b", rsp_data, exp_rsp(2'b11, 8'h12, 8'h33));
    pop_rsp();
    chk("t3_rsp_empty", rsp_valid, 0);
    chk("t3_ovf_sticky", err_ovf, 1);
    push(mk(1'b1, 2'b00, 8'h20, 8'h5A));
    pulse_start(2'b11);
    chk("t3_ovf_cleared", err_ovf, 0);
    chk("t3_cfg", driver_cfg, 2'b11);
    pulse_read(8'hEE);
    gap();
    pulse_read(8'hEE);
    chk("t3_wr_norsp", rsp_valid, 0);
    gap();

    // Test 4: asynchronous reset mid-batch, then a tagged read (test 6)
    for (int i = 0; i < 3; i++) push(mk(1'b0, 2'b01, 8'h30 + 8'(i), 8'h00));
    pulse_start(2'b10);
    pulse_read(8'hEE);
    gap();
    pulse_read(8'h55);
    chk("t4_pre_rsp", rsp_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_master_en", master_en, 0);
    chk("t4_busy", busy, 0);
    chk("t4_done", done, 0);
    chk("t4_driver_data", driver_data, 0);
    chk("t4_driver_cfg", driver_cfg, 0);
    chk("t4_cmd_ready", cmd_ready, 1);
    chk("t4_rsp_valid", rsp_valid, 0);
    chk("t4_rsp_data", rsp_data, 0);
    chk("t4_err_ovf", err_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    t6 = mk(1'b0, 2'b10, 8'h1C, 8'h00);
    push(t6);
    pulse_start(2'b01);
    chk("t4_new_head", driver_data, t6);
    pulse_read(8'hEE);
    chk("t4_no_stale_rsp", rsp_valid, 0);
    gap();
    pulse_read(8'h77);
    chk("t6_done", done, 1);
    chk("t6_rsp_valid", rsp_valid, 1);
    chk("t6_rsp_data", rsp_data, exp_rsp(2'b10, 8'h1C, 8'h77));
    pop_rsp();
    gap();

    // Test 5: late push extends the batch; push on closing pulse waits
    base = done_cnt;
    w2 = mk(1'b1, 2'b00, 8'h41, 8'h02);
    w3 = mk(1'b1, 2'b00, 8'h42, 8'h03);
    push(mk(1'b1, 2'b00, 8'h40, 8'h01));
    pulse_start(2'b00);
    pulse_read(8'hEE);
    gap();
    push(w2);
    chk("t5_en_mid", master_en, 1);
    chk("t5_late_head", driver_data, w2);
    pulse_read(8'hEE);
    chk("t5_extended", master_en, 1);
    gap();
    cmd_valid = 1'b1; cmd_data = w3; driver_read = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; driver_read = 1'b0;
    chk("t5_close_en", master_en, 0);
    chk("t5_close_done", done, 1);
    @(negedge clk);
    chk("t5_busy_end", busy, 0);
    pulse_start(2'b00);
    chk("t5_retained_en", master_en, 1);
    chk("t5_retained_head", driver_data, w3);
    pulse_read(8'hEE);
    gap();
    pulse_read(8'hEE);
    chk("t5_done2", done, 1);
    gap();
    chk("t5_done_count", done_cnt - base, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
